// File: rtl/register_file_mp_pkg.sv
// Shared constants for the multi-port register file.
//   DEF_DATA_W / DEF_ADDR_W / DEF_NUM_RD : default build geometry
//   ZERO_ADDR                            : address of the hardwired-zero register
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;
  localparam int ZERO_ADDR  = 0;

endpackage : regfile_pkg

// File: rtl/register_file_mp_scoreboard.sv
// Per-register busy (pending-producer) flags with a registered population count.
//   clk, rst             : clock, synchronous active-high reset
//   clr0_en / clr0_addr  : committed write on port 0 clears its target flag
//   clr1_en / clr1_addr  : committed write on port 1 clears its target flag
//   set_en / set_addr    : marks a register busy; wins over a same-edge clear
//   flags                : current flag vector, one bit per register
//   count                : number of flags set, updated with the flags
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr0_en,
  input  logic [ADDR_W-1:0]     clr0_addr,
  input  logic                  clr1_en,
  input  logic [ADDR_W-1:0]     clr1_addr,
  input  logic                  set_en,
  input  logic [ADDR_W-1:0]     set_addr,
  output logic [2**ADDR_W-1:0]  flags,
  output logic [ADDR_W:0]       count
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] flags_reg;
  logic [DEPTH-1:0] flags_next;
  logic [ADDR_W:0]  count_reg;
  logic [ADDR_W:0]  count_next;

  // Clears are applied first so a new producer claiming the same register
  // in the same cycle leaves it busy.
  always_comb begin
    flags_next = flags_reg;
    if (clr0_en) flags_next[clr0_addr] = 1'b0;
    if (clr1_en) flags_next[clr1_addr] = 1'b0;
    if (set_en)  flags_next[set_addr]  = 1'b1;
  end

  // Count is taken from the next-state vector so it lands on the same edge
  // as the flags it describes.
  always_comb begin
    count_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_next = count_next + (ADDR_W+1)'(flags_next[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_reg <= '0;
    end else begin
      flags_reg <= flags_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign flags = flags_reg;
  assign count = count_reg;

endmodule : regfile_scoreboard

// File: rtl/register_file_mp.sv
// Multi-port register file: NUM_RD combinational read ports, two write ports
// (port 1 has priority), optional same-cycle write forwarding, optional
// hardwired zero register, and per-register busy tracking.
//   clk, rst                 : clock, synchronous active-high reset
//   rd_addr / rd_data        : packed read addresses / data, port i = slice i
//   rd_busy                  : per-port busy flag of the addressed register
//   we0/waddr0/wdata0        : write port 0
//   we1/waddr1/wdata1        : write port 1 (wins on address collision)
//   busy_set / busy_addr     : mark a register as awaiting a producer
//   busy_count               : registered number of busy registers
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic                     busy_set,
  input  logic [ADDR_W-1:0]        busy_addr,
  output logic [ADDR_W:0]          busy_count
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(ZERO_ADDR);

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [DEPTH-1:0]  busy_flags;

  // Effective events: anything aimed at the zero register is dropped, and
  // nothing counts while reset is asserted.
  logic we0_eff, we1_eff, set_eff;

  assign we0_eff = we0 && !rst && !((ZERO_REG != 0) && (waddr0 == ZADDR));
  assign we1_eff = we1 && !rst && !((ZERO_REG != 0) && (waddr1 == ZADDR));
  assign set_eff = busy_set && !rst && !((ZERO_REG != 0) && (busy_addr == ZADDR));

  // Port 1 is written after port 0 so it takes the collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      if (we0_eff) mem_reg[waddr0] <= wdata0;
      if (we1_eff) mem_reg[waddr1] <= wdata1;
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .clr0_en   (we0_eff),
    .clr0_addr (waddr0),
    .clr1_en   (we1_eff),
    .clr1_addr (waddr1),
    .set_en    (set_eff),
    .set_addr  (busy_addr),
    .flags     (busy_flags),
    .count     (busy_count)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic              hit0, hit1, set_hit, addr_zero;
      logic [DATA_W-1:0] data_sel;

      assign addr      = rd_addr[gi*ADDR_W +: ADDR_W];
      assign hit0      = (BYPASS != 0) && we0_eff && (waddr0 == addr);
      assign hit1      = (BYPASS != 0) && we1_eff && (waddr1 == addr);
      assign set_hit   = set_eff && (busy_addr == addr);
      assign addr_zero = (ZERO_REG != 0) && (addr == ZADDR);

      always_comb begin
        data_sel = mem_reg[addr];
        if (hit1) begin
          data_sel = wdata1;
        end else if (hit0) begin
          data_sel = wdata0;
        end
        if (addr_zero) data_sel = '0;
      end

      assign rd_data[gi*DATA_W +: DATA_W] = data_sel;

      // A forwarded write retires the pending producer unless a new one
      // claims the register on the same edge.
      assign rd_busy[gi] = (hit0 || hit1) ? set_hit : busy_flags[addr];
    end
  endgenerate

endmodule : register_file_mp

// File: tb/tb_register_file_mp.sv
// Randomized scoreboard bench for register_file_mp. Two instances share all
// inputs: one with forwarding (BYPASS=1) and one without (BYPASS=0). The
// driver pushes expected outputs per cycle; a monitor pops and compares.
module tb_register_file_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data_b, rd_data_n;
  logic [1:0]  rd_busy_b, rd_busy_n;
  logic        we0, we1, busy_set;
  logic [4:0]  waddr0, waddr1, busy_addr;
  logic [31:0] wdata0, wdata1;
  logic [5:0]  busy_count_b, busy_count_n;

  always #5 clk = ~clk;

  register_file_mp #(.BYPASS(1)) u_dut_b (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .busy_set(busy_set), .busy_addr(busy_addr), .busy_count(busy_count_b)
  );

  register_file_mp #(.BYPASS(0)) u_dut_n (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .busy_set(busy_set), .busy_addr(busy_addr), .busy_count(busy_count_n)
  );

  typedef struct packed {
    logic [31:0] cyc;
    logic [63:0] data_b;
    logic [63:0] data_n;
    logic [1:0]  busy_b;
    logic [1:0]  busy_n;
    logic [5:0]  cnt;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: architectural register contents and busy set.
  logic [31:0] m_mem [32];
  bit          m_busy [32];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;

  function automatic int popc();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  task automatic check(input string name, input int c, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, req);
    end
  endtask

  // One clock of stimulus; called at posedge+1. chk=0 skips the expectation.
  task automatic drive(input bit chk, input bit r,
                       input bit w0, input logic [4:0] a0, input logic [31:0] d0,
                       input bit w1, input logic [4:0] a1, input logic [31:0] d1,
                       input bit bs, input logic [4:0] ba,
                       input logic [4:0] ra0, input logic [4:0] ra1);
    exp_t e;
    bit w0e, w1e, se, hit;
    logic [4:0] a;
    logic [31:0] bd;
    rst = r; we0 = w0; waddr0 = a0; wdata0 = d0;
    we1 = w1; waddr1 = a1; wdata1 = d1;
    busy_set = bs; busy_addr = ba; rd_addr = {ra1, ra0};
    w0e = !r && w0 && (a0 != 5'd0);
    w1e = !r && w1 && (a1 != 5'd0);
    se  = !r && bs && (ba != 5'd0);
    e = '0;
    e.cyc = cyc;
    for (int p = 0; p < 2; p++) begin
      a = (p == 1) ? ra1 : ra0;
      hit = (w1e && a1 == a) || (w0e && a0 == a);
      if (w1e && a1 == a)      bd = d1;
      else if (w0e && a0 == a) bd = d0;
      else                     bd = m_mem[a];
      if (a == 5'd0) bd = '0;
      e.data_b[p*32 +: 32] = bd;
      e.busy_b[p]          = hit ? (se && ba == a) : m_busy[a];
      e.data_n[p*32 +: 32] = m_mem[a];
      e.busy_n[p]          = m_busy[a];
    end
    e.cnt = 6'(popc());
    if (chk) exp_q.push_back(e);
    // Advance the model to the post-edge state.
    if (r) begin
      for (int i = 0; i < 32; i++) begin m_mem[i] = '0; m_busy[i] = 0; end
    end else begin
      if (w0e) begin m_mem[a0] = d0; m_busy[a0] = 0; end
      if (w1e) begin m_mem[a1] = d1; m_busy[a1] = 0; end
      if (se)  m_busy[ba] = 1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic rd(input logic [4:0] ra0, input logic [4:0] ra1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, ra0, ra1);
  endtask

  // Monitor: outputs are sampled on the falling edge, mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("rd_data_byp",  int'(e.cyc), {32'd0, rd_data_b}, {32'd0, e.data_b});
      check("rd_data_nobyp", int'(e.cyc), {32'd0, rd_data_n}, {32'd0, e.data_n});
      check("rd_busy_byp",  int'(e.cyc), 64'(rd_busy_b), 64'(e.busy_b));
      check("rd_busy_nobyp", int'(e.cyc), 64'(rd_busy_n), 64'(e.busy_n));
      check("busy_count_byp",  int'(e.cyc), 64'(busy_count_b), 64'(e.cnt));
      check("busy_count_nobyp", int'(e.cyc), 64'(busy_count_n), 64'(e.cnt));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] a0, a1, ba, r0, r1;
    rst = 1; we0 = 0; we1 = 0; busy_set = 0;
    waddr0 = 0; waddr1 = 0; wdata0 = 0; wdata1 = 0; busy_addr = 0; rd_addr = 0;
    for (int i = 0; i < 32; i++) begin m_mem[i] = '0; m_busy[i] = 0; end
    @(posedge clk);
    #1;
    // Reset one cycle, then sweep every address.
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 16; k++) rd(5'(2*k), 5'(2*k+1));
    // Same-address dual write: port 1 wins, forwarded same cycle.
    drive(1, 0, 1, 5, 32'h1111, 1, 5, 32'h2222, 0, 0, 5, 5);
    rd(5, 0);
    // Zero register: write discarded, busy never set.
    drive(1, 0, 0, 0, 0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5);
    rd(0, 0);
    // Busy set / write-clear race / clear.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    rd(7, 7);
    drive(1, 0, 1, 7, 32'h77, 0, 0, 0, 1, 7, 7, 0);
    rd(7, 0);
    drive(1, 0, 1, 7, 32'h78, 0, 0, 0, 0, 0, 7, 0);
    rd(7, 0);
    // Forwarding vs stored value on r3.
    drive(1, 0, 1, 3, 32'hABCD, 0, 0, 0, 0, 0, 3, 3);
    rd(3, 0);
    // Reset mid-operation overrides pending write and set.
    for (int i = 1; i <= 4; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 5'(i), 5'(i), 9);
    drive(1, 0, 1, 9, 32'h55, 0, 0, 0, 0, 0, 9, 1);
    rd(9, 4);
    drive(0, 1, 0, 0, 0, 1, 9, 32'h77, 1, 5, 9, 1);
    rd(9, 1);
    rd(4, 5);
    // Random traffic, addresses often drawn from a small pool to collide.
    for (int n = 0; n < 600; n++) begin
      a0 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      a1 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      ba = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      r0 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      r1 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        drive(0, 1, 1'($urandom), a0, $urandom, 1'($urandom), a1, $urandom, 1'($urandom), ba, r0, r1);
      end else begin
        drive(1, 0, $urandom_range(0, 2) == 0, a0, $urandom, $urandom_range(0, 2) == 0, a1, $urandom,
              $urandom_range(0, 2) == 0, ba, r0, r1);
      end
    end
    rd(0, 0);
    @(posedge clk);
    #1;
    check("queue_drained", cyc, 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_register_file_mp
